// File: rtl/qspi_psram_model.sv
// QSPI/QPI PSRAM slave model with NUM_CS independent byte-wide banks.
// sck, ce_n and io are oversampled in the clk domain, so clk must run at >= 4x sck.
module qspi_psram_model #(
  parameter int ADDR_BITS = 12,
  parameter int NUM_CS    = 2,
  parameter int RD_WAIT   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CS-1:0] ce_n,
  input  logic              sck,
  input  logic [3:0]        dio_in,
  output logic [3:0]        dio_out,
  output logic [3:0]        dio_oe
);

  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int IDX_W = CS_W + ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WAIT, RDATA, WDATA
  } state_t;

  state_t               state_reg;
  logic                 sck_s1_reg, sck_s2_reg, sck_prev_reg;
  logic [NUM_CS-1:0]    ce_s1_reg, ce_s2_reg;
  logic [3:0]           din_s1_reg, din_s2_reg;
  logic                 valid_prev_reg;
  logic                 armed_reg;
  logic                 qpi_reg, rst_en_reg;
  logic [7:0]           cmd_sh_reg, cmd_reg;
  logic                 cmd_done_reg;
  logic                 quad_reg, read_reg;
  logic [7:0]           wait_reg, cnt_reg;
  logic [23:0]          addr_sh_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [CS_W-1:0]      bank_reg;
  logic [7:0]           wsh_reg, dsh_reg;
  logic                 wr_en_reg;
  logic [IDX_W-1:0]     wr_idx_reg;
  logic [7:0]           wr_data_reg, rd_data_reg;
  logic [3:0]           dio_out_reg, dio_oe_reg;

  logic                 sck_rise, sck_fall, valid;
  logic [CS_W-1:0]      sel_idx;
  logic [7:0]           cmd_next, wsh_next, out_byte;
  logic [23:0]          addr_next;
  logic                 cmd_last, addr_last, data_last;

  assign sck_rise = sck_s2_reg & ~sck_prev_reg;
  assign sck_fall = ~sck_s2_reg & sck_prev_reg;

  // A bank is addressed only when exactly one select line is low.
  always_comb begin
    valid   = ($countones(~ce_s2_reg) == 1);
    sel_idx = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (!ce_s2_reg[i]) sel_idx = CS_W'(i);
    end
  end

  assign cmd_next  = qpi_reg  ? {cmd_sh_reg[3:0], din_s2_reg}   : {cmd_sh_reg[6:0], din_s2_reg[0]};
  assign addr_next = quad_reg ? {addr_sh_reg[19:0], din_s2_reg} : {addr_sh_reg[22:0], din_s2_reg[0]};
  assign wsh_next  = quad_reg ? {wsh_reg[3:0], din_s2_reg}      : {wsh_reg[6:0], din_s2_reg[0]};
  assign out_byte  = (cnt_reg == 8'd0) ? rd_data_reg : dsh_reg;
  assign cmd_last  = (cnt_reg == (qpi_reg  ? 8'd1 : 8'd7));
  assign addr_last = (cnt_reg == (quad_reg ? 8'd5 : 8'd23));
  assign data_last = (cnt_reg == (quad_reg ? 8'd1 : 8'd7));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      sck_s1_reg     <= 1'b0;
      sck_s2_reg     <= 1'b0;
      sck_prev_reg   <= 1'b0;
      ce_s1_reg      <= '1;
      ce_s2_reg      <= '1;
      din_s1_reg     <= '0;
      din_s2_reg     <= '0;
      valid_prev_reg <= 1'b0;
      armed_reg      <= 1'b1;
      qpi_reg        <= 1'b0;
      rst_en_reg     <= 1'b0;
      cmd_sh_reg     <= '0;
      cmd_reg        <= '0;
      cmd_done_reg   <= 1'b0;
      quad_reg       <= 1'b0;
      read_reg       <= 1'b0;
      wait_reg       <= '0;
      cnt_reg        <= '0;
      addr_sh_reg    <= '0;
      addr_reg       <= '0;
      bank_reg       <= '0;
      wsh_reg        <= '0;
      dsh_reg        <= '0;
      wr_en_reg      <= 1'b0;
      wr_idx_reg     <= '0;
      wr_data_reg    <= '0;
      dio_out_reg    <= '0;
      dio_oe_reg     <= '0;
    end else begin
      sck_s1_reg     <= sck;
      sck_s2_reg     <= sck_s1_reg;
      sck_prev_reg   <= sck_s2_reg;
      ce_s1_reg      <= ce_n;
      ce_s2_reg      <= ce_s1_reg;
      din_s1_reg     <= dio_in;
      din_s2_reg     <= din_s1_reg;
      valid_prev_reg <= valid;
      wr_en_reg      <= 1'b0;

      if (!valid) begin
        state_reg   <= IDLE;
        armed_reg   <= 1'b1;
        dio_oe_reg  <= '0;
        dio_out_reg <= '0;
        // Mode commands act when their transaction closes; 0x66 arms only the very next command.
        if (valid_prev_reg && cmd_done_reg) begin
          cmd_done_reg <= 1'b0;
          rst_en_reg   <= (cmd_reg == 8'h66);
          case (cmd_reg)
            8'h35:   qpi_reg <= 1'b1;
            8'hF5:   qpi_reg <= 1'b0;
            8'h99:   if (rst_en_reg) qpi_reg <= 1'b0;
            default: ;
          endcase
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (armed_reg) begin
              armed_reg <= 1'b0;
              bank_reg  <= sel_idx;
              cnt_reg   <= '0;
              state_reg <= CMD;
            end
          end

          CMD: begin
            if (sck_rise) begin
              cmd_sh_reg <= cmd_next;
              cnt_reg    <= cnt_reg + 8'd1;
              if (cmd_last) begin
                cmd_reg      <= cmd_next;
                cmd_done_reg <= 1'b1;
                cnt_reg      <= '0;
                state_reg    <= ADDR;
                case (cmd_next)
                  8'h03, 8'h0B: begin
                    read_reg <= 1'b1;
                    quad_reg <= qpi_reg;
                    if (qpi_reg)
                      wait_reg <= 8'(RD_WAIT);
                    else
                      wait_reg <= (cmd_next == 8'h0B) ? 8'd8 : 8'd0;
                  end
                  8'hEB: begin
                    read_reg <= 1'b1;
                    quad_reg <= 1'b1;
                    wait_reg <= 8'(RD_WAIT);
                  end
                  8'h02: begin
                    read_reg <= 1'b0;
                    quad_reg <= qpi_reg;
                  end
                  8'h38: begin
                    read_reg <= 1'b0;
                    quad_reg <= 1'b1;
                  end
                  // Mode and unknown commands: park until deselect with outputs off.
                  default: state_reg <= IDLE;
                endcase
              end
            end
          end

          ADDR: begin
            if (sck_rise) begin
              addr_sh_reg <= addr_next;
              cnt_reg     <= cnt_reg + 8'd1;
              if (addr_last) begin
                addr_reg <= addr_next[ADDR_BITS-1:0];
                cnt_reg  <= '0;
                if (!read_reg)
                  state_reg <= WDATA;
                else if (wait_reg == 8'd0)
                  state_reg <= RDATA;
                else
                  state_reg <= WAIT;
              end
            end
          end

          WAIT: begin
            if (sck_rise) begin
              if (cnt_reg == wait_reg - 8'd1) begin
                cnt_reg   <= '0;
                state_reg <= RDATA;
              end else begin
                cnt_reg <= cnt_reg + 8'd1;
              end
            end
          end

          RDATA: begin
            if (sck_fall) begin
              if (quad_reg) begin
                dio_out_reg <= out_byte[7:4];
                dio_oe_reg  <= 4'hF;
                dsh_reg     <= {out_byte[3:0], 4'h0};
              end else begin
                dio_out_reg <= {2'b00, out_byte[7], 1'b0};
                dio_oe_reg  <= 4'b0010;
                dsh_reg     <= {out_byte[6:0], 1'b0};
              end
              if (data_last) begin
                cnt_reg  <= '0;
                addr_reg <= addr_reg + ADDR_BITS'(1);
              end else begin
                cnt_reg <= cnt_reg + 8'd1;
              end
            end
          end

          WDATA: begin
            if (sck_rise) begin
              wsh_reg <= wsh_next;
              cnt_reg <= cnt_reg + 8'd1;
              // Only a complete byte reaches memory; a partial one dies with deselect.
              if (data_last) begin
                cnt_reg     <= '0;
                wr_en_reg   <= 1'b1;
                wr_idx_reg  <= {bank_reg, addr_reg};
                wr_data_reg <= wsh_next;
                addr_reg    <= addr_reg + ADDR_BITS'(1);
              end
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Storage survives reset; banks are separated by the upper index bits.
  logic [7:0] mem [0:(1<<IDX_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en_reg) mem[wr_idx_reg] <= wr_data_reg;
    rd_data_reg <= mem[{bank_reg, addr_reg}];
  end

  assign dio_out = dio_out_reg;
  assign dio_oe  = dio_oe_reg;

endmodule

// File: tb/tb_qspi_psram_model.sv
// Bench for qspi_psram_model: directed and randomized bus transactions
// checked against a per-bank byte-array model of the memory and mode flag.
module tb_qspi_psram_model;
  localparam int ADDR_BITS = 12;
  localparam int NUM_CS    = 2;
  localparam int RD_WAIT   = 6;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam int HALF      = 60;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              sck    = 1'b0;
  logic [NUM_CS-1:0] ce_n   = '1;
  logic [3:0]        dio_in = '0;
  logic [3:0]        dio_out, dio_oe;

  int         total = 0;
  int         bad   = 0;
  bit         m_qpi = 1'b0;
  logic [7:0] ref_mem [NUM_CS][DEPTH];

  qspi_psram_model #(
    .ADDR_BITS(ADDR_BITS),
    .NUM_CS   (NUM_CS),
    .RD_WAIT  (RD_WAIT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce_n   (ce_n),
    .sck    (sck),
    .dio_in (dio_in),
    .dio_out(dio_out),
    .dio_oe (dio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sck period: drive io while sck is low, sample just before the rising edge.
  task automatic bus_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    dio_in = d;
    #(HALF);
    q   = dio_out;
    oe  = dio_oe;
    sck = 1'b1;
    #(HALF);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit quad);
    logic [3:0] q, oe;
    if (quad) begin
      bus_cycle(v[7:4], q, oe);
      bus_cycle(v[3:0], q, oe);
    end else begin
      for (int i = 7; i >= 0; i--) bus_cycle({3'b000, v[i]}, q, oe);
    end
  endtask

  task automatic recv_byte(input bit quad, output logic [7:0] v, output bit oe_ok);
    logic [3:0] q, oe;
    oe_ok = 1'b1;
    v     = '0;
    if (quad) begin
      for (int i = 0; i < 2; i++) begin
        bus_cycle(4'h0, q, oe);
        v = {v[3:0], q};
        if (oe !== 4'hF) oe_ok = 1'b0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        bus_cycle(4'h0, q, oe);
        v = {v[6:0], q[1]};
        if (oe !== 4'b0010) oe_ok = 1'b0;
      end
    end
  endtask

  task automatic select(input int b);
    @(negedge clk);
    ce_n    = '1;
    ce_n[b] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic deselect();
    repeat (4) @(negedge clk);
    ce_n = '1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_cmd_addr(input int b, input logic [7:0] cmd, input int addr, input bit quad_addr);
    select(b);
    send_byte(cmd, m_qpi);
    for (int i = 2; i >= 0; i--) send_byte(8'(addr >> (8 * i)), quad_addr);
  endtask

  task automatic do_write(input int b, input int addr, input bit quad_cmd, input logic [7:0] data[$]);
    bit quad;
    quad = m_qpi || quad_cmd;
    send_cmd_addr(b, quad_cmd ? 8'h38 : 8'h02, addr, quad);
    foreach (data[i]) begin
      send_byte(data[i], quad);
      ref_mem[b][(addr + i) % DEPTH] = data[i];
    end
    deselect();
  endtask

  task automatic do_read(input string tag, input int b, input int addr, input logic [7:0] cmd, input int n);
    bit         quad, oe_ok;
    int         waits;
    logic [3:0] q, oe, wait_oe;
    logic [7:0] v;
    quad  = m_qpi || (cmd == 8'hEB);
    waits = quad ? RD_WAIT : ((cmd == 8'h0B) ? 8 : 0);
    send_cmd_addr(b, cmd, addr, quad);
    wait_oe = '0;
    for (int i = 0; i < waits; i++) begin
      bus_cycle(4'h0, q, oe);
      wait_oe |= oe;
    end
    if (waits > 0) check({tag, "_wait_oe"}, wait_oe, 4'h0);
    for (int i = 0; i < n; i++) begin
      recv_byte(quad, v, oe_ok);
      check($sformatf("%s_data%0d", tag, i), v, ref_mem[b][(addr + i) % DEPTH]);
      check($sformatf("%s_oe%0d", tag, i), oe_ok, 1);
    end
    deselect();
  endtask

  initial begin
    logic [7:0] q8;
    logic [3:0] q, oe, acc;
    logic [7:0] data[$];
    logic [7:0] rcmd;
    int         b, a, n;
    bit         qc, ok;

    repeat (3) @(negedge clk);
    check("rst_oe", dio_oe, 4'h0);
    check("rst_out", dio_out, 4'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_oe", dio_oe, 4'h0);

    // SPI write/read, including a write that wraps past the top of bank 0
    data = {8'h5C, 8'hC5};
    do_write(0, 'hFFF, 0, data);
    data = {8'hA5, 8'h3C};
    do_write(0, 'h010, 0, data);
    do_read("spi_rd", 0, 'h010, 8'h03, 2);

    // Quad write with wrap on bank 1, quad read, bank 0 untouched
    data = {8'h11, 8'h22};
    do_write(1, 'hFFF, 1, data);
    do_read("quad_rd", 1, 'hFFF, 8'hEB, 2);
    do_read("wrap_rd", 1, 'h000, 8'h03, 1);
    do_read("bank0_keep", 0, 'hFFF, 8'h0B, 2);
    do_read("hi_addr", 0, 'h7A5010, 8'h03, 1);

    // Randomized SPI-mode traffic
    for (int k = 0; k < 8; k++) begin
      b  = $urandom_range(0, NUM_CS - 1);
      a  = $urandom_range(0, DEPTH - 1);
      n  = $urandom_range(1, 3);
      qc = 1'($urandom_range(0, 1));
      data = {};
      for (int i = 0; i < n; i++) data.push_back(8'($urandom));
      do_write(b, a, qc, data);
      case ($urandom_range(0, 2))
        0:       rcmd = 8'h03;
        1:       rcmd = 8'h0B;
        default: rcmd = 8'hEB;
      endcase
      do_read($sformatf("rnd%0d", k), b, a, rcmd, n);
    end

    // Unknown command keeps the bus released
    select(1);
    send_byte(8'hAB, 0);
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      bus_cycle(4'($urandom), q, oe);
      acc |= oe;
    end
    deselect();
    check("unk_oe", acc, 4'h0);

    // QPI round trip, reset-enable disarm, then a real reset back to SPI
    select(0);
    send_byte(8'h35, 0);
    deselect();
    m_qpi = 1'b1;
    data = {8'hDE, 8'hAD};
    do_write(0, 'h020, 0, data);
    do_read("qpi_rd", 0, 'h020, 8'h03, 2);
    do_read("qpi_fast", 0, 'h010, 8'h0B, 1);
    select(0);
    send_byte(8'h66, 1);
    deselect();
    do_read("qpi_mid", 0, 'h020, 8'hEB, 1);
    select(0);
    send_byte(8'h99, 1);
    deselect();
    do_read("qpi_kept", 0, 'h020, 8'h03, 2);
    select(0);
    send_byte(8'h66, 1);
    deselect();
    select(0);
    send_byte(8'h99, 1);
    deselect();
    m_qpi = 1'b0;
    do_read("spi_after_rst", 0, 'h010, 8'h03, 1);

    // Mode flag is shared: enter via bank 1, exit with 0xF5
    select(1);
    send_byte(8'h35, 0);
    deselect();
    m_qpi = 1'b1;
    do_read("qpi_bank1", 1, 'hFFF, 8'h03, 2);
    select(1);
    send_byte(8'hF5, 1);
    deselect();
    m_qpi = 1'b0;
    do_read("spi_after_f5", 1, 'h000, 8'h03, 1);

    // Partial byte at deselect is dropped
    data = {8'h00, 8'h5A};
    do_write(0, 'h100, 0, data);
    send_cmd_addr(0, 8'h02, 'h100, 0);
    send_byte(8'h77, 0);
    for (int i = 0; i < 4; i++) bus_cycle(4'h1, q, oe);
    deselect();
    ref_mem[0]['h100] = 8'h77;
    do_read("partial", 0, 'h100, 8'h03, 2);

    // Two banks selected at once: no write, no drive
    data = {8'h3C};
    do_write(1, 'h200, 0, data);
    send_cmd_addr(1, 8'h02, 'h200, 0);
    ce_n = '0;
    acc  = '0;
    for (int i = 0; i < 8; i++) begin
      bus_cycle(4'h1, q, oe);
      acc |= oe;
    end
    deselect();
    check("both_sel_wr_oe", acc, 4'h0);
    do_read("both_sel_wr", 1, 'h200, 8'h03, 1);

    send_cmd_addr(0, 8'h03, 'h010, 0);
    recv_byte(0, q8, ok);
    check("rd_before_both", q8, ref_mem[0]['h010]);
    ce_n = '0;
    acc  = '0;
    for (int i = 0; i < 4; i++) begin
      bus_cycle(4'h0, q, oe);
      acc |= oe;
    end
    deselect();
    check("both_sel_rd_oe", acc, 4'h0);

    // Reset in the middle of a QPI read
    select(0);
    send_byte(8'h35, 0);
    deselect();
    m_qpi = 1'b1;
    send_cmd_addr(0, 8'h03, 'h010, 1);
    for (int i = 0; i < RD_WAIT; i++) bus_cycle(4'h0, q, oe);
    recv_byte(1, q8, ok);
    check("pre_rst_data", q8, ref_mem[0]['h010]);
    repeat (4) @(negedge clk);
    check("pre_rst_oe", dio_oe, 4'hF);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_oe", dio_oe, 4'h0);
    ce_n = '1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_qpi = 1'b0;
    repeat (4) @(negedge clk);
    do_read("after_rst", 0, 'h010, 8'h03, 2);
    do_read("after_rst_b1", 1, 'h200, 8'h03, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: run did not complete, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/qspi_psram_model.md
QSPI_PSRAM_MODEL -- requirements
Module: qspi_psram_model

Interface
REQ-001 Parameter ADDR_BITS, default 12: bytes per bank = 2^ADDR_BITS; address bits above ADDR_BITS-1 are ignored.
REQ-002 Parameter NUM_CS, default 2: number of independent banks, each with its own chip-select.
REQ-003 Parameter RD_WAIT, default 6: dummy sck cycles for quad/QPI reads.
REQ-004 clk  input  1  system clock, single clock domain for all logic.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ce_n  input  NUM_CS  active-low bank selects.
REQ-007 sck  input  1  SPI clock; sampled in the clk domain, clk frequency >= 4x sck frequency.
REQ-008 dio_in  input  4  io[3:0] from the bus.
REQ-009 dio_out  output  4  io[3:0] drive values.
REQ-010 dio_oe  output  4  per-bit output enable, 1 = drive.

Function
REQ-011 sck and ce_n SHALL pass through a 2-flop synchronizer; rise = sync high & previous low; fall = the converse.
REQ-012 The bank is valid only when exactly one ce_n bit is low; zero or more than one low means deselected: FSM to IDLE, dio_oe = 0.
REQ-013 Input bits SHALL be sampled on sck rise; output bits SHALL be updated on sck fall.
REQ-014 FSM states: IDLE, CMD, ADDR, WAIT, RDATA, WDATA; IDLE->CMD on valid select; any state -> IDLE on deselect.
REQ-015 Global mode flag qpi (0 = SPI, 1 = QPI), shared by all banks.
REQ-016 SPI mode: command 8 bits MSB first on io0; QPI mode: command as 2 nibbles on io[3:0].
REQ-017 Commands: 0x03 read, 0x0B fast read, 0x02 write, 0xEB quad read, 0x38 quad write, 0x35 enter QPI, 0xF5 exit QPI, 0x66 reset-enable, 0x99 reset.
REQ-018 Address is 24 bits MSB first: on io0 for 0x03/0x0B/0x02 in SPI mode; as 6 nibbles on io[3:0] for 0xEB/0x38 and for every command in QPI mode.
REQ-019 Wait cycles: 0x03 = 0; 0x0B = 8 in SPI mode; 0xEB and any QPI-mode read = RD_WAIT.
REQ-020 SPI read data: MSB first on io1 with dio_oe = 4'b0010; quad read data: high nibble first on io[3:0] with dio_oe = 4'hF.
REQ-021 The first output bit/nibble SHALL be driven on the sck fall that ends the last address/wait cycle.
REQ-022 Write data is shifted in on io0 (SPI) or io[3:0] (quad); a byte is committed to the selected bank only after all 8 bits are received.
REQ-023 The byte address SHALL increment after each byte and wrap modulo 2^ADDR_BITS within the selected bank.
REQ-024 Unknown command: ignore remaining cycles, dio_oe = 0 until deselect.
REQ-025 0x35/0xF5 take effect at deselect; 0x99 directly following a 0x66 transaction SHALL clear qpi; any other intervening command disarms 0x66.
REQ-026 Deselect mid-byte SHALL discard the partial write byte; committed bytes are kept.
REQ-027 Each bank SHALL have separate storage; writes to bank k SHALL never alter bank j.

Reset
REQ-028 On rst_n low: FSM = IDLE, qpi = 0, reset-enable = 0, dio_out = 0, dio_oe = 0, synchronizers = deselected / sck low.
REQ-029 Memory contents SHALL NOT be cleared by reset; reset mid-transaction aborts with no commit of the partial byte.

Verification
REQ-030 SPI write 0x02, addr 0x000010, data A5 3C on bank 0; then SPI read 0x03 at 0x000010 -> io1 returns A5 then 3C, dio_oe = 4'b0010.
REQ-031 Quad write 0x38 to bank 1 at 0x000FFF with data 11 22 -> 0x11 at 0xFFF, 0x22 at 0x000 (wrap, ADDR_BITS=12); bank 0 at the same addresses unchanged.
REQ-032 Quad read 0xEB at 0x000FFF -> exactly RD_WAIT = 6 dummy cycles with dio_oe = 0, then nibbles 1,1,2,2 with dio_oe = 4'hF.
REQ-033 Send 0x35, deselect, QPI write/read round-trip of 0xDEAD at 0x20 -> read returns DE AD; then 0x66, 0x99 -> a subsequent SPI 0x03 read works.
REQ-034 Send 0x02, 12 data bits (a full 0x77 byte plus one nibble), then deselect -> 0x77 is stored, the next address is unchanged; ce_n = 2'b00 during a transfer -> dio_oe = 0, no write.
REQ-035 Assert rst_n low mid-read -> dio_oe = 0 the following clk; qpi = 0; previously written data still reads back.
